jtag_interface_dr: RTL

JTAG_INTERFACE_DR -- requirements
Module: jtag_interface_dr

---
 rtl/jtag_interface_dr_pkg.sv | 43 ++++
 rtl/jtag_interface_dr.sv | 108 ++++++++++
 2 files changed

// File: rtl/jtag_interface_dr_pkg.sv
// ---------------------------------------------------------------------------
// jtag_interface_dr_pkg
// Shared JTAG data-register definitions: instruction opcodes, DR lengths,
// data width and the instruction-to-DR decode used by jtag_interface_dr.
// ---------------------------------------------------------------------------
package jtag_interface_dr_pkg;

    localparam int TAP_INSTR_WIDTH = 4;
    localparam int DATA_WIDTH      = 64;

    localparam logic [TAP_INSTR_WIDTH-1:0] TAP_IDCODE  = 4'h1;
    localparam logic [TAP_INSTR_WIDTH-1:0] TAP_DATA_WR = 4'h2;
    localparam logic [TAP_INSTR_WIDTH-1:0] TAP_DATA_RD = 4'h3;
    localparam logic [TAP_INSTR_WIDTH-1:0] TAP_STATUS  = 4'h4;
    localparam logic [TAP_INSTR_WIDTH-1:0] TAP_BYPASS  = 4'hF;

    localparam int IDCODE_LEN  = 32;
    localparam int DATA_WR_LEN = 64;
    localparam int DATA_RD_LEN = 64;
    localparam int STATUS_LEN  = 8;

    typedef enum logic [2:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_DATA_WR,
        DR_DATA_RD,
        DR_STATUS
    } dr_sel_e;

    // Any opcode not explicitly listed selects the bypass register.
    function automatic dr_sel_e decode_instr(input logic [TAP_INSTR_WIDTH-1:0] instr);
        dr_sel_e sel;
        case (instr)
            TAP_IDCODE:  sel = DR_IDCODE;
            TAP_DATA_WR: sel = DR_DATA_WR;
            TAP_DATA_RD: sel = DR_DATA_RD;
            TAP_STATUS:  sel = DR_STATUS;
            default:     sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_interface_dr.sv
// ---------------------------------------------------------------------------
// jtag_interface_dr
// JTAG data-register block: one shared 64-bit shift register whose active
// length depends on the decoded instruction, plus a chip-side write request
// (valid/ready) with a sticky overflow flag readable through STATUS.
//
// Ports
//   tck               JTAG clock, all flops on posedge
//   rst               asynchronous active-high reset
//   instructions      active instruction from the TAP
//   capture_dr_state  TAP in Capture-DR
//   shift_dr_state    TAP in Shift-DR
//   update_dr_state   TAP in Update-DR
//   tdi               serial data in
//   so                DR serial out (SR[0], registered)
//   bypass_sel        TAP should use its own bypass flop
//   wr_valid/wr_data  chip-side write request
//   wr_ready          chip-side write accept
//   rd_data           chip-side readback value
// ---------------------------------------------------------------------------
module jtag_interface_dr
    import jtag_interface_dr_pkg::*;
#(
    parameter logic [IDCODE_LEN-1:0] IDCODE_VALUE = 32'h0000_1DB3
) (
    input  logic                       tck,
    input  logic                       rst,
    input  logic [TAP_INSTR_WIDTH-1:0] instructions,
    input  logic                       capture_dr_state,
    input  logic                       shift_dr_state,
    input  logic                       update_dr_state,
    input  logic                       tdi,
    output logic                       so,
    output logic                       bypass_sel,
    output logic                       wr_valid,
    output logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_ready,
    input  logic [DATA_WIDTH-1:0]      rd_data
);

    dr_sel_e               dr_sel;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  overflow_q, overflow_d;

    assign dr_sel     = decode_instr(instructions);
    assign bypass_sel = (dr_sel == DR_BYPASS);
    assign so         = sr_q[0];
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;

    always_comb begin
        sr_d       = sr_q;
        wr_data_d  = wr_data_q;
        overflow_d = overflow_q;
        // A handshake retires the pending write unless an update reloads it below.
        wr_valid_d = wr_valid_q & ~wr_ready;

        if (capture_dr_state) begin
            case (dr_sel)
                DR_IDCODE:  sr_d = {{(DATA_WIDTH-IDCODE_LEN){1'b0}}, IDCODE_VALUE};
                DR_DATA_RD: sr_d = rd_data;
                DR_STATUS:  sr_d = {{(DATA_WIDTH-2){1'b0}}, overflow_q, wr_valid_q};
                DR_DATA_WR: sr_d = wr_data_q;
                default:    sr_d = sr_q;
            endcase
        end else if (shift_dr_state) begin
            // tdi enters at the top of the active window; bits above it are untouched.
            case (dr_sel)
                DR_IDCODE:  sr_d = {sr_q[DATA_WIDTH-1:IDCODE_LEN], tdi, sr_q[IDCODE_LEN-1:1]};
                DR_DATA_WR,
                DR_DATA_RD: sr_d = {tdi, sr_q[DATA_WIDTH-1:1]};
                DR_STATUS:  sr_d = {sr_q[DATA_WIDTH-1:STATUS_LEN], tdi, sr_q[STATUS_LEN-1:1]};
                default:    sr_d = sr_q;
            endcase
        end else if (update_dr_state) begin
            case (dr_sel)
                DR_DATA_WR: begin
                    if (wr_valid_q && !wr_ready) begin
                        // Previous write still pending: drop the new word.
                        overflow_d = 1'b1;
                    end else begin
                        wr_data_d  = sr_q;
                        wr_valid_d = 1'b1;
                    end
                end
                DR_STATUS: overflow_d = 1'b0;
                default:   overflow_d = overflow_q;
            endcase
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
